// File: rtl/cpu_stack_engine_pkg.sv
// Shared definitions for the stack engine: operation codes and FSM state encodings.
// The control unit imports the same op codes when it issues call/ret/push/pop.
package cpu_stack_engine_pkg;

  localparam logic [1:0] OP_PUSH  = 2'd0;
  localparam logic [1:0] OP_POP   = 2'd1;
  localparam logic [1:0] OP_PEEK  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WREQ  = 2'd1,
    ST_RREQ  = 2'd2,
    ST_RWAIT = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_stack_engine_if.sv
// Operation/response handshake plus data-memory request bus of the stack engine.
// slave = the engine itself, master = control unit and memory arbiter side.
interface cpu_stack_engine_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic              op_valid;
  logic              op_ready;
  logic [1:0]        op_code;
  logic [DATA_W-1:0] op_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output op_valid, op_code, op_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  op_ready, rsp_valid, rsp_data, rsp_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  op_valid, op_code, op_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output op_ready, rsp_valid, rsp_data, rsp_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cpu_stack_engine_reg.sv
// Enable-loaded register with asynchronous active-low reset to a parameterised value.
module cpu_stack_engine_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cpu_stack_engine.sv
// Sequenced stack-pointer / stack-access engine: one outstanding op at a time,
// downward-growing stack in data memory with overflow/underflow rejection.
module cpu_stack_engine
  import cpu_stack_engine_pkg::*;
#(
  parameter int  DATA_W     = 16,
  parameter int  ADDR_W     = 9,
  parameter int  STACK_BASE = 0,
  parameter int  DEPTH      = 64,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  cpu_stack_engine_if.slave  bus,
  output logic [ADDR_W-1:0]  sp,
  output logic [CNT_W-1:0]   count,
  output logic               empty,
  output logic               full,
  output logic               ovf_sticky,
  output logic               unf_sticky
);

  localparam logic [ADDR_W-1:0] SP_BASE = ADDR_W'(STACK_BASE);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);

  state_t            state_reg, state_next;
  logic [1:0]        op_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              rsp_valid_reg, rsp_valid_next;
  logic              rsp_err_reg, rsp_err_next;
  logic              ovf_reg, ovf_next;
  logic              unf_reg, unf_next;
  logic              accept;
  logic              sp_en, cnt_en, rdata_en;
  logic [ADDR_W-1:0] sp_next;
  logic [CNT_W-1:0]  cnt_next;
  logic [DATA_W-1:0] rsp_data_q;

  assign accept = bus.op_valid && (state_reg == ST_IDLE);
  assign empty  = (count == '0);
  assign full   = (count == CNT_MAX);

  always_comb begin
    state_next     = state_reg;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    ovf_next       = ovf_reg;
    unf_next       = unf_reg;
    sp_en          = 1'b0;
    sp_next        = sp;
    cnt_en         = 1'b0;
    cnt_next       = count;
    rdata_en       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (bus.op_code)
            OP_PUSH: begin
              if (full) begin
                rsp_valid_next = 1'b1;
                rsp_err_next   = 1'b1;
                ovf_next       = 1'b1;
              end else begin
                state_next = ST_WREQ;
              end
            end
            OP_CLEAR: begin
              sp_en          = 1'b1;
              sp_next        = SP_BASE;
              cnt_en         = 1'b1;
              cnt_next       = '0;
              ovf_next       = 1'b0;
              unf_next       = 1'b0;
              rsp_valid_next = 1'b1;
            end
            default: begin
              // POP and PEEK share the underflow check and the read path
              if (empty) begin
                rsp_valid_next = 1'b1;
                rsp_err_next   = 1'b1;
                unf_next       = 1'b1;
              end else begin
                state_next = ST_RREQ;
              end
            end
          endcase
        end
      end
      ST_WREQ: begin
        if (bus.mem_gnt) begin
          sp_en          = 1'b1;
          sp_next        = sp - ADDR_W'(1);
          cnt_en         = 1'b1;
          cnt_next       = count + CNT_W'(1);
          rsp_valid_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end
      ST_RREQ: begin
        if (bus.mem_gnt) begin
          state_next = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (bus.mem_rvalid) begin
          rdata_en       = 1'b1;
          rsp_valid_next = 1'b1;
          state_next     = ST_IDLE;
          if (op_reg == OP_POP) begin
            sp_en    = 1'b1;
            sp_next  = sp + ADDR_W'(1);
            cnt_en   = 1'b1;
            cnt_next = count - CNT_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_PUSH;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      ovf_reg       <= 1'b0;
      unf_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      ovf_reg       <= ovf_next;
      unf_reg       <= unf_next;
      if (accept) begin
        op_reg    <= bus.op_code;
        wdata_reg <= bus.op_wdata;
      end
    end
  end

  cpu_stack_engine_reg #(.W(ADDR_W), .RST_VAL(SP_BASE)) u_sp (
    .clk(clk), .rst(rst), .en(sp_en), .d(sp_next), .q(sp)
  );

  cpu_stack_engine_reg #(.W(CNT_W), .RST_VAL('0)) u_count (
    .clk(clk), .rst(rst), .en(cnt_en), .d(cnt_next), .q(count)
  );

  cpu_stack_engine_reg #(.W(DATA_W), .RST_VAL('0)) u_rsp_data (
    .clk(clk), .rst(rst), .en(rdata_en), .d(bus.mem_rdata), .q(rsp_data_q)
  );

  // Address/data are pure functions of state and sp, so they stay stable until grant
  assign bus.op_ready  = (state_reg == ST_IDLE);
  assign bus.mem_req   = (state_reg == ST_WREQ) || (state_reg == ST_RREQ);
  assign bus.mem_we    = (state_reg == ST_WREQ);
  assign bus.mem_addr  = (state_reg == ST_WREQ) ? (sp - ADDR_W'(1)) : sp;
  assign bus.mem_wdata = wdata_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.rsp_data  = rsp_data_q;
  assign ovf_sticky    = ovf_reg;
  assign unf_sticky    = unf_reg;

endmodule

// File: tb/tb_cpu_stack_engine.sv
// Bench for cpu_stack_engine: queue-based stack model checked every cycle, a
// memory responder with programmable grant/rvalid delays, and directed scenarios.
module tb_cpu_stack_engine;
  import cpu_stack_engine_pkg::*;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 9;
  localparam int STACK_BASE = 0;
  localparam int DEPTH      = 4;
  localparam int CNT_W      = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ADDR_W-1:0] sp;
  logic [CNT_W-1:0]  count;
  logic empty, full, ovf_sticky, unf_sticky;

  cpu_stack_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  cpu_stack_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STACK_BASE(STACK_BASE), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .sp(sp), .count(count), .empty(empty),
    .full(full), .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int gnt_delay = 0, rv_delay = 0, req_cycles = 0, n_gnt = 0, rv_cnt = 0;
  bit rv_pending = 0;
  logic [DATA_W-1:0] rv_data;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_wdata;

  initial begin
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (rv_pending) begin
        if (rv_cnt == 0) begin
          bus.mem_rvalid = 1'b1; bus.mem_rdata = rv_data; rv_pending = 0;
        end else rv_cnt--;
      end
      if (bus.mem_req) begin
        if (req_cycles >= gnt_delay) begin
          bus.mem_gnt = 1'b1; req_cycles = 0; n_gnt++; last_addr = bus.mem_addr;
          if (bus.mem_we) begin
            mem[bus.mem_addr] = bus.mem_wdata; last_wdata = bus.mem_wdata;
          end else begin
            rv_pending = 1; rv_cnt = rv_delay; rv_data = mem[bus.mem_addr];
          end
        end else req_cycles++;
      end else req_cycles = 0;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct packed { logic [1:0] code; logic [DATA_W-1:0] wd; } op_t;
  op_t pend[$];
  logic [DATA_W-1:0] stk[$];   // stk[0] is the top of stack
  bit m_ovf = 0, m_unf = 0;
  op_t cur, nop;
  logic e_err, ok;
  logic [DATA_W-1:0] dropped;

  function automatic logic [ADDR_W-1:0] model_sp(input int delta);
    return ADDR_W'(STACK_BASE - stk.size() + delta);
  endfunction

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      pend.delete(); stk.delete(); m_ovf = 0; m_unf = 0;
    end
    if (bus.rsp_valid) begin
      chk("rsp_expected", 32'(pend.size() != 0), 1);
      if (pend.size() != 0) begin
        cur = pend.pop_front();
        e_err = 1'b0;
        case (cur.code)
          OP_PUSH: begin
            e_err = (stk.size() == DEPTH);
            if (e_err) m_ovf = 1; else stk.push_front(cur.wd);
          end
          OP_POP, OP_PEEK: begin
            e_err = (stk.size() == 0);
            if (e_err) m_unf = 1;
            else begin
              chk("rsp_data", bus.rsp_data, stk[0]);
              if (cur.code == OP_POP) dropped = stk.pop_front();
            end
          end
          default: begin
            stk.delete(); m_ovf = 0; m_unf = 0;
          end
        endcase
        chk("rsp_err", bus.rsp_err, e_err);
      end
    end else begin
      chk("rsp_err_idle", bus.rsp_err, 0);
    end
    chk("sp", sp, model_sp(0));
    chk("count", count, stk.size());
    chk("empty", empty, stk.size() == 0);
    chk("full", full, stk.size() == DEPTH);
    chk("ovf_sticky", ovf_sticky, m_ovf);
    chk("unf_sticky", unf_sticky, m_unf);
    chk("op_ready", bus.op_ready, pend.size() == 0);
    if (bus.mem_req) begin
      ok = 1'b0;
      if (pend.size() == 1) begin
        if (pend[0].code == OP_PUSH) ok = (stk.size() < DEPTH);
        else if (pend[0].code != OP_CLEAR) ok = (stk.size() > 0);
      end
      chk("mem_req_legal", ok, 1);
      if (ok) begin
        if (pend[0].code == OP_PUSH) begin
          chk("mem_we", bus.mem_we, 1);
          chk("mem_addr", bus.mem_addr, model_sp(-1));
          chk("mem_wdata", bus.mem_wdata, pend[0].wd);
        end else begin
          chk("mem_we", bus.mem_we, 0);
          chk("mem_addr", bus.mem_addr, model_sp(0));
        end
      end
    end
    if (rst && bus.op_valid && bus.op_ready) begin
      nop.code = bus.op_code; nop.wd = bus.op_wdata;
      pend.push_back(nop);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_op(input logic [1:0] code, input logic [DATA_W-1:0] wd,
                       output int lat, output logic err, output logic [DATA_W-1:0] rd);
    int g;
    g = 0;
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_code = code; bus.op_wdata = wd;
    while (!bus.op_ready && g < 50) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("rsp_timeout", bus.rsp_valid, 1);
    err = bus.rsp_err; rd = bus.rsp_data;
    $display("op code=%0d wd=%h lat=%0d err=%0b rd=%h sp=%h count=%0d",
             code, wd, lat, err, rd, sp, count);
  endtask

  int lat, n, g0, n_rsp;
  logic err;
  logic [DATA_W-1:0] rd;

  initial begin
    bus.op_valid = 1'b0; bus.op_code = OP_PUSH; bus.op_wdata = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_sp", sp, 0);           chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);     chk("rst_full", full, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0); chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);   chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_ovf", ovf_sticky, 0);  chk("rst_unf", unf_sticky, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_op_ready", bus.op_ready, 1);

    // 1: first PUSH wraps to the top of the address space
    do_op(OP_PUSH, 16'hABCD, lat, err, rd);
    chk("t1_lat", lat, 2); chk("t1_addr", last_addr, 9'h1FF);
    chk("t1_wdata", last_wdata, 16'hABCD); chk("t1_sp", sp, 9'h1FF); chk("t1_count", count, 1);

    // 2: POP with rvalid two cycles after grant
    rv_delay = 1;
    do_op(OP_POP, 16'h0000, lat, err, rd);
    chk("t2_lat", lat, 4); chk("t2_err", err, 0); chk("t2_data", rd, 16'hABCD);
    chk("t2_sp", sp, 0); chk("t2_count", count, 0); chk("t2_empty", empty, 1);
    rv_delay = 0;

    // 4: PEEK underflow, then PUSH + PEEK
    do_op(OP_PEEK, 16'h0000, lat, err, rd);
    chk("t4_lat", lat, 1); chk("t4_err", err, 1); chk("t4_unf", unf_sticky, 1);
    do_op(OP_PUSH, 16'h0042, lat, err, rd);
    do_op(OP_PEEK, 16'h0000, lat, err, rd);
    chk("t4_peek_lat", lat, 3); chk("t4_peek_data", rd, 16'h0042);
    chk("t4_sp", sp, 9'h1FF); chk("t4_count", count, 1);

    // 5: grant withheld; op_valid kept high with a CLEAR that must be ignored
    gnt_delay = 5;
    @(posedge clk); #1;
    chk("t5_ready_pre", bus.op_ready, 1);
    bus.op_valid = 1'b1; bus.op_code = OP_PUSH; bus.op_wdata = 16'h1234;
    @(posedge clk); #1;
    bus.op_code = OP_CLEAR;
    n = 0;
    while (bus.mem_req && n < 20) begin
      chk("t5_addr", bus.mem_addr, 9'h1FE); chk("t5_wdata", bus.mem_wdata, 16'h1234);
      chk("t5_ready", bus.op_ready, 0);
      @(posedge clk); #1; n++;
    end
    bus.op_valid = 1'b0;
    chk("t5_req_cycles", n, 6); chk("t5_rsp_after_gnt", bus.rsp_valid, 1);
    chk("t5_sp", sp, 9'h1FE); chk("t5_count", count, 2);
    $display("op withheld-grant push req_cycles=%0d sp=%h count=%0d", n, sp, count);
    gnt_delay = 0;

    // 3: CLEAR, fill to DEPTH, overflow, CLEAR
    do_op(OP_CLEAR, 16'h0000, lat, err, rd);
    chk("t3_clr_lat", lat, 1); chk("t3_clr_err", err, 0); chk("t3_clr_unf", unf_sticky, 0);
    for (int i = 0; i < 5; i++) begin
      g0 = n_gnt;
      do_op(OP_PUSH, 16'(16'h1000 + i), lat, err, rd);
      if (i == 4) begin
        chk("t3_ovf_lat", lat, 1); chk("t3_ovf_err", err, 1);
        chk("t3_ovf_no_mem", n_gnt, g0); chk("t3_ovf_sticky", ovf_sticky, 1);
        chk("t3_ovf_count", count, 4); chk("t3_full", full, 1);
      end
    end
    do_op(OP_CLEAR, 16'h0000, lat, err, rd);
    chk("t3_sp", sp, 0); chk("t3_count", count, 0); chk("t3_ovf_clr", ovf_sticky, 0);

    // LIFO ordering with mixed latencies
    gnt_delay = 0; do_op(OP_PUSH, 16'h1111, lat, err, rd);
    gnt_delay = 2; do_op(OP_PUSH, 16'h2222, lat, err, rd);
    gnt_delay = 1; do_op(OP_PUSH, 16'h3333, lat, err, rd);
    chk("lifo_sp", sp, 9'h1FD);
    gnt_delay = 0; rv_delay = 2; do_op(OP_POP, 16'h0000, lat, err, rd);
    chk("lifo_d0", rd, 16'h3333); chk("lifo_l0", lat, 5);
    rv_delay = 0; do_op(OP_POP, 16'h0000, lat, err, rd);
    chk("lifo_d1", rd, 16'h2222); chk("lifo_l1", lat, 3);
    gnt_delay = 3; rv_delay = 1; do_op(OP_POP, 16'h0000, lat, err, rd);
    chk("lifo_d2", rd, 16'h1111); chk("lifo_l2", lat, 7);
    gnt_delay = 0; rv_delay = 0;

    // 6: reset during RWAIT, stale rvalid afterwards
    do_op(OP_PUSH, 16'h5A5A, lat, err, rd);
    rv_delay = 4;
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_code = OP_POP;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6_rwait_req", bus.mem_req, 0); chk("t6_rwait_ready", bus.op_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_rsp = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) n_rsp++;
    end
    chk("t6_no_rsp", n_rsp, 0); chk("t6_sp", sp, 0); chk("t6_count", count, 0);
    chk("t6_ready", bus.op_ready, 1); chk("t6_rsp_data", bus.rsp_data, 0);
    $display("op reset-in-rwait rsp_seen=%0d sp=%h count=%0d", n_rsp, sp, count);
    rv_delay = 0;

    do_op(OP_POP, 16'h0000, lat, err, rd);
    chk("post_pop_err", err, 1); chk("post_unf", unf_sticky, 1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_stack_engine.md
Name: cpu_stack_engine

Overview:
- Parametrised stack-pointer and stack-access engine for the next-generation core.
- Replaces the fixed 9-bit SP register and its combinational push/pop address muxing with a sequenced unit.
- Adds configurable width, depth and base, a variable-latency memory handshake, overflow/underflow detection, PEEK and CLEAR operations.
- Sits between the control unit (which issues stack ops such as call/ret/push/pop) and the data-memory arbiter.

Parameters:
DATA_W, 16, stack word width
ADDR_W, 9, data-memory address width; SP width
STACK_BASE, 0, SP reset/empty value; stack grows downward from here, modulo 2^ADDR_W
DEPTH, 64, maximum live entries; legal range 1..2^ADDR_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
op_valid  in  1  operation request
op_ready  out  1  engine can accept an operation
op_code  in  2  0=PUSH, 1=POP, 2=PEEK, 3=CLEAR
op_wdata  in  DATA_W  PUSH data (return address for calls, zero-extended by the caller)
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  DATA_W  POP/PEEK result; held until next rsp_valid
rsp_err  out  1  qualifies rsp_valid: operation rejected (overflow or underflow)
mem_req  out  1  memory request; held until granted
mem_we  out  1  1=write, 0=read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  write data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  read data
sp  out  ADDR_W  current stack pointer (address of top entry when count>0)
count  out  $clog2(DEPTH+1)  live entries
empty  out  1  count==0
full  out  1  count==DEPTH
ovf_sticky  out  1  a PUSH was rejected since the last CLEAR/reset
unf_sticky  out  1  a POP/PEEK was rejected since the last CLEAR/reset

Behaviour:
- Reset (rst low, async):
  - state=IDLE, sp=STACK_BASE, count=0.
  - mem_req=0, mem_we=0, rsp_valid=0, rsp_err=0, rsp_data=0, stickies=0.
  - op_ready=1 after reset releases.
  - An op in flight is abandoned; no SP update.
- FSM states: IDLE, WREQ, RREQ, RWAIT.
- IDLE: op_ready=1. An op is accepted on op_valid&op_ready (cycle T); op_code and op_wdata are latched.
  - PUSH with full=1: no memory access; rsp_valid=1 and rsp_err=1 at T+1; ovf_sticky set; sp/count unchanged.
  - POP or PEEK with empty=1: same as above, but unf_sticky is set.
  - CLEAR: at T+1 sp=STACK_BASE, count=0, stickies cleared, rsp_valid=1, rsp_err=0. No memory access.
  - Legal PUSH: go to WREQ. mem_addr=sp-1 (mod 2^ADDR_W), mem_we=1, mem_wdata=latched data.
  - Legal POP/PEEK: go to RREQ. mem_addr=sp, mem_we=0.
- WREQ: mem_req=1 with address and data stable until mem_gnt.
  - On the grant cycle G: sp<=sp-1, count<=count+1, go to IDLE.
  - rsp_valid=1 and op_ready=1 at G+1.
- RREQ: mem_req=1 until mem_gnt, then RWAIT. mem_rvalid is ignored in RREQ.
- RWAIT: on the mem_rvalid cycle R: rsp_data<=mem_rdata, go to IDLE, rsp_valid=1 at R+1.
  - POP additionally: sp<=sp+1, count<=count-1 at R.
  - PEEK: sp/count unchanged.
- mem_rvalid outside RWAIT is ignored, including stale responses after reset.
- op_ready=0 in every non-IDLE state, so at most one op is outstanding.
- Minimum latency:
  - PUSH: 2 cycles from acceptance to rsp_valid with immediate grant.
  - POP: 3 cycles with immediate grant and rvalid one cycle after grant.
  - Error/CLEAR: 1 cycle.
- Wrap-around: SP arithmetic is modulo 2^ADDR_W. With STACK_BASE=0 the first PUSH writes address 2^ADDR_W-1.
- empty/full are derived from count only, never from SP comparison.
- rsp_valid is a single-cycle pulse; rsp_err=0 whenever rsp_valid=0.

Decomposition:
- Shared package: op_code constants (OP_PUSH, OP_POP, OP_PEEK, OP_CLEAR) and FSM state encodings, reused by the control unit.
- One sub-module: the parametrised register (width, enable, async active-low reset) instantiated for sp, count and rsp_data.

Test Plan:
1. Reset, STACK_BASE=0, ADDR_W=9: PUSH 16'hABCD with immediate gnt -> mem_addr=9'h1FF, mem_wdata=16'hABCD, rsp_valid at T+2, sp=9'h1FF, count=1.
2. After test 1, POP with gnt at T+1 and rvalid at T+3 carrying 16'hABCD -> rsp_valid at T+4, rsp_data=16'hABCD, sp=0, count=0, empty=1.
3. DEPTH=4: five PUSHes -> fifth gives rsp_err=1 at T+1, no mem_req, ovf_sticky=1, count=4; then CLEAR -> sp=0, count=0, ovf_sticky=0.
4. Empty stack: PEEK -> rsp_err=1, unf_sticky=1. Then PUSH 16'h0042 and PEEK -> rsp_data=16'h0042, sp=9'h1FF and count=1 unchanged.
5. PUSH with gnt withheld 5 cycles -> mem_req and mem_addr stable throughout, op_ready=0, op_valid ignored; completion 1 cycle after gnt.
6. Assert rst low during RWAIT of a POP, then deliver mem_rvalid after release -> sp=STACK_BASE, no rsp_valid, state IDLE, op_ready=1.
